ascii_seq_receiver: RTL

Receiving end of the one-character-per-second ASCII status bus driven by the top-level character sequencer. It samples the 8-bit character bus and accepts a character once the bus has been stable long enough. It decodes each accepted character back to the sender's 4-bit sequence index (A..F → 0..5, '0'..'9' → 6..15). It checks that successive indices advance by one (mod 16) and reports lock status, error pulses and counters. It is used on the bring-up board and in loopback benches to verify the sequencer output.

---
 rtl/ascii_seq_receiver.sv | 111 +++++++++++
 1 files changed

// File: rtl/ascii_seq_receiver.sv
// Receiver for the one-character-per-second ASCII status bus: filters the bus,
// decodes accepted characters to sequence indices and tracks sequence lock.
module ascii_seq_receiver #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  output logic [3:0] nibble_out,
  output logic       char_valid,
  output logic       char_invalid,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] rx_count,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {UNLOCKED, TRACK, LOCKED} state_t;

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES - 1);

  state_t     state;
  logic [7:0] sync_q;
  logic [7:0] cand;
  logic [7:0] last_acc;
  logic [7:0] stab_cnt;
  logic [3:0] expected;
  logic       dec_valid;
  logic [3:0] dec_idx;

  // Letters A..F map to 0..5, digits map to 6..15; blank and others are not valid.
  always_comb begin
    dec_valid = 1'b0;
    dec_idx   = 4'd0;
    if (cand >= 8'h41 && cand <= 8'h46) begin
      dec_valid = 1'b1;
      dec_idx   = 4'(cand[3:0] - 4'd1);
    end else if (cand >= 8'h30 && cand <= 8'h39) begin
      dec_valid = 1'b1;
      dec_idx   = 4'(cand[3:0] + 4'd6);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= 8'h00;
      cand         <= 8'h00;
      last_acc     <= 8'h00;
      stab_cnt     <= 8'd0;
      state        <= UNLOCKED;
      expected     <= 4'd0;
      nibble_out   <= 4'd0;
      char_valid   <= 1'b0;
      char_invalid <= 1'b0;
      seq_err      <= 1'b0;
      locked       <= 1'b0;
      rx_count     <= 8'd0;
      err_count    <= 8'd0;
    end else begin
      sync_q       <= char_in;
      char_valid   <= 1'b0;
      char_invalid <= 1'b0;
      seq_err      <= 1'b0;
      if (sync_q != cand) begin
        cand     <= sync_q;
        stab_cnt <= 8'd0;
      end else if (stab_cnt == STAB_MAX && cand != last_acc) begin
        last_acc <= cand;
        if (dec_valid) begin
          nibble_out <= dec_idx;
          char_valid <= 1'b1;
          rx_count   <= rx_count + 8'd1;
          expected   <= dec_idx + 4'd1;
          case (state)
            UNLOCKED: begin
              state  <= TRACK;
              locked <= 1'b0;
            end
            TRACK: begin
              if (dec_idx == expected) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
            LOCKED: begin
              if (dec_idx != expected) begin
                seq_err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                state  <= TRACK;
                locked <= 1'b0;
              end
            end
            default: begin
              state  <= UNLOCKED;
              locked <= 1'b0;
            end
          endcase
        end else if (cand != 8'h00) begin
          // Blank updates last_acc only; anything else is a bus error.
          char_invalid <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + 8'd1;
      end
    end
  end

endmodule
